// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA timing/control engine.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HREQ,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4
  } dma_state_t;

  // ch_dir encoding
  localparam logic DIR_IO_TO_MEM = 1'b1;  // IOR + MEMW
  localparam logic DIR_MEM_TO_IO = 1'b0;  // MEMR + IOW

  localparam int unsigned DEF_NUM_CH   = 4;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_WAIT_MAX = 15;
  localparam int unsigned DEF_ROTATE   = 0;

  // States in which the bus is held and loss of HLDA is an error.
  function automatic logic in_bus_cycle(input dma_state_t s);
    return (s == ST_S1) || (s == ST_S2) || (s == ST_S3);
  endfunction

endpackage

// File: rtl/dma_prio_arbiter.sv
// NUM_CH-wide priority encoder: fixed (lowest index wins) or rotating
// (search begins at channel 'start' and wraps).
module dma_prio_arbiter
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned ROTATE = DEF_ROTATE
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] start,
  output logic                      grant_vld,
  output logic [$clog2(NUM_CH)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  // First requesting channel in search order starting from the base index.
  always_comb begin : arb
    int unsigned j;
    logic [IDX_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    j         = 0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      j = (ROTATE != 0) ? (i + 32'(start)) : i;
      if (j >= NUM_CH) j = j - NUM_CH;
      idx = IDX_W'(j);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/dma_timing_ctrl.sv
// Multi-channel DMA timing and control: arbitration, HRQ/HLDA handshake,
// S1-S4 transfer sequencing with wait states, per-channel transfer counters.
module dma_timing_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned WAIT_MAX = DEF_WAIT_MAX,
  parameter int unsigned ROTATE   = DEF_ROTATE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cs,
  input  logic                      cnt_wr,
  input  logic [$clog2(NUM_CH)-1:0] cnt_sel,
  input  logic [CNT_W-1:0]          cnt_data,
  input  logic [NUM_CH-1:0]         dreq,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic [NUM_CH-1:0]         ch_dir,
  input  logic [NUM_CH-1:0]         ch_block,
  input  logic                      hlda,
  input  logic                      ready,
  output logic                      hrq,
  output logic                      aen,
  output logic [NUM_CH-1:0]         dack,
  output logic                      ior_n,
  output logic                      iow_n,
  output logic                      memr_n,
  output logic                      memw_n,
  output logic                      addr_inc,
  output logic [$clog2(NUM_CH)-1:0] cur_ch,
  output logic                      eop,
  output logic [NUM_CH-1:0]         tc_status,
  output logic                      err
);

  localparam int unsigned IDX_W  = $clog2(NUM_CH);
  localparam int unsigned WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  dma_state_t        state, state_nxt;
  logic [IDX_W-1:0]  ch_nxt;
  logic              err_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [IDX_W-1:0]  ptr;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] cnt_zero;
  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic              cnt_ld;
  logic              owns_nxt;
  logic              rd_phase;
  logic              wr_phase;
  logic              dir_nxt;

  assign eligible = dreq & ~ch_mask & ~tc_status;
  assign cnt_ld   = cnt_wr && !cs && !((state != ST_IDLE) && (cnt_sel == cur_ch));

  dma_prio_arbiter #(
    .NUM_CH (NUM_CH),
    .ROTATE (ROTATE)
  ) u_arb (
    .req       (eligible),
    .start     (ptr),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // Next-state selection; HLDA loss during S1-S3 overrides every other path.
  always_comb begin
    state_nxt = state;
    ch_nxt    = cur_ch;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          state_nxt = ST_HREQ;
          ch_nxt    = grant_idx;
        end
      end
      ST_HREQ: if (hlda) state_nxt = ST_S1;
      ST_S1:   state_nxt = ST_S2;
      ST_S2:   state_nxt = ST_S3;
      ST_S3: begin
        if (ready) begin
          state_nxt = ST_S4;
        end else if (wait_cnt == WAIT_LIM) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
      ST_S4: begin
        if (!cnt_zero[cur_ch] && ch_block[cur_ch] && eligible[cur_ch])
          state_nxt = ST_S1;
        else
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (in_bus_cycle(state) && !hlda) begin
      state_nxt = ST_IDLE;
      err_nxt   = 1'b1;
    end
  end

  assign owns_nxt = (state_nxt == ST_S1) || (state_nxt == ST_S2) ||
                    (state_nxt == ST_S3) || (state_nxt == ST_S4);
  assign rd_phase = (state_nxt == ST_S2) || (state_nxt == ST_S3);
  assign wr_phase = (state_nxt == ST_S3);
  assign dir_nxt  = ch_dir[ch_nxt];

  // State register with outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cur_ch   <= '0;
      hrq      <= 1'b0;
      aen      <= 1'b0;
      dack     <= '0;
      ior_n    <= 1'b1;
      iow_n    <= 1'b1;
      memr_n   <= 1'b1;
      memw_n   <= 1'b1;
      addr_inc <= 1'b0;
      eop      <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
      ptr      <= '0;
    end else begin
      state    <= state_nxt;
      cur_ch   <= ch_nxt;
      hrq      <= (state_nxt != ST_IDLE);
      aen      <= owns_nxt;
      dack     <= owns_nxt ? (NUM_CH'(1) << ch_nxt) : '0;
      ior_n    <= !(rd_phase && (dir_nxt == DIR_IO_TO_MEM));
      memr_n   <= !(rd_phase && (dir_nxt == DIR_MEM_TO_IO));
      memw_n   <= !(wr_phase && (dir_nxt == DIR_IO_TO_MEM));
      iow_n    <= !(wr_phase && (dir_nxt == DIR_MEM_TO_IO));
      addr_inc <= (state_nxt == ST_S4);
      eop      <= (state_nxt == ST_S4) && cnt_zero[cur_ch];
      err      <= err_nxt;
      wait_cnt <= (state == ST_S3 && !ready && wait_cnt != WAIT_LIM) ? wait_cnt + 1'b1 : '0;
      // ptr holds the next search start, so reset value 0 gives ch0 first
      if (state != ST_S4 && state_nxt == ST_S4)
        ptr <= (cur_ch == IDX_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [IDX_W-1:0] CH = IDX_W'(g);
    logic [CNT_W-1:0] cnt_q;
    logic             tc_q;

    // Per-channel counter: host load, decrement in S4, sticky TC at zero.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        tc_q  <= 1'b0;
      end else if (cnt_ld && cnt_sel == CH) begin
        cnt_q <= cnt_data;
        tc_q  <= 1'b0;
      end else if (state == ST_S4 && cur_ch == CH) begin
        if (cnt_q == '0) tc_q  <= 1'b1;
        else             cnt_q <= cnt_q - 1'b1;
      end
    end

    assign cnt_zero[g]  = (cnt_q == '0);
    assign tc_status[g] = tc_q;
  end

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Directed bench for dma_timing_ctrl: a fixed-priority and a rotating-priority
// instance share stimulus; completed transfers are scored against queues.
module tb_dma_timing_ctrl;

  typedef struct packed {
    logic [1:0] ch;
    logic       eop;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset, cs, cnt_wr, hlda, ready;
  logic [1:0]  cnt_sel;
  logic [15:0] cnt_data;
  logic [3:0]  dreq, ch_mask, ch_dir, ch_block;

  logic       hrq0, aen0, ior_n0, iow_n0, memr_n0, memw_n0, addr_inc0, eop0, err0;
  logic [3:0] dack0, tc0;
  logic [1:0] cur0;
  logic       hrq1, aen1, ior_n1, iow_n1, memr_n1, memw_n1, addr_inc1, eop1, err1;
  logic [3:0] dack1, tc1;
  logic [1:0] cur1;

  int unsigned n_pass = 0, n_chk = 0, n_fail = 0;
  xfer_t q0[$], q1[$];

  // {hrq, aen, dack, ior_n, iow_n, memr_n, memw_n, addr_inc, eop, err, cur_ch, tc_status}
  logic [18:0] st0, st1;
  localparam logic [18:0] RST_VEC = {1'b0, 1'b0, 4'b0000, 4'b1111, 3'b000, 2'b00, 4'b0000};
  assign st0 = {hrq0, aen0, dack0, ior_n0, iow_n0, memr_n0, memw_n0, addr_inc0, eop0, err0, cur0, tc0};
  assign st1 = {hrq1, aen1, dack1, ior_n1, iow_n1, memr_n1, memw_n1, addr_inc1, eop1, err1, cur1, tc1};

  always #5 clk = ~clk;

  dma_timing_ctrl #(.NUM_CH(4), .CNT_W(16), .WAIT_MAX(15), .ROTATE(0)) dut0 (
    .clk(clk), .reset(reset), .cs(cs), .cnt_wr(cnt_wr), .cnt_sel(cnt_sel),
    .cnt_data(cnt_data), .dreq(dreq), .ch_mask(ch_mask), .ch_dir(ch_dir),
    .ch_block(ch_block), .hlda(hlda), .ready(ready), .hrq(hrq0), .aen(aen0),
    .dack(dack0), .ior_n(ior_n0), .iow_n(iow_n0), .memr_n(memr_n0),
    .memw_n(memw_n0), .addr_inc(addr_inc0), .cur_ch(cur0), .eop(eop0),
    .tc_status(tc0), .err(err0));

  dma_timing_ctrl #(.NUM_CH(4), .CNT_W(16), .WAIT_MAX(15), .ROTATE(1)) dut1 (
    .clk(clk), .reset(reset), .cs(cs), .cnt_wr(cnt_wr), .cnt_sel(cnt_sel),
    .cnt_data(cnt_data), .dreq(dreq), .ch_mask(ch_mask), .ch_dir(ch_dir),
    .ch_block(ch_block), .hlda(hlda), .ready(ready), .hrq(hrq1), .aen(aen1),
    .dack(dack1), .ior_n(ior_n1), .iow_n(iow_n1), .memr_n(memr_n1),
    .memw_n(memw_n1), .addr_inc(addr_inc1), .cur_ch(cur1), .eop(eop1),
    .tc_status(tc1), .err(err1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cnt(input logic [1:0] sel, input logic [15:0] val);
    cs = 1'b0; cnt_wr = 1'b1; cnt_sel = sel; cnt_data = val;
    tick();
    cs = 1'b1; cnt_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; dreq = '0; hlda = 1'b0; ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push_both(input logic [1:0] ch, input logic e);
    q0.push_back('{ch: ch, eop: e});
    q1.push_back('{ch: ch, eop: e});
  endtask

  // Scoreboard: every addr_inc pulse retires one expected transfer.
  always @(negedge clk) begin
    xfer_t e;
    if (!reset) begin
      if (addr_inc0) begin
        check("dut0 xfer expected", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          check("dut0 xfer ch", cur0, e.ch);
          check("dut0 xfer eop", eop0, e.eop);
        end
      end
      if (addr_inc1) begin
        check("dut1 xfer expected", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check("dut1 xfer ch", cur1, e.ch);
          check("dut1 xfer eop", eop1, e.eop);
        end
      end
      if (eop0) check("dut0 eop with addr_inc", addr_inc0, 1);
      if (eop1) check("dut1 eop with addr_inc", addr_inc1, 1);
    end
  end

  initial begin
    int n_inc, n_hrq_lo, eop_at, s3_len, n_err;
    reset = 1'b1; cs = 1'b1; cnt_wr = 1'b0; cnt_sel = '0; cnt_data = '0;
    dreq = '0; ch_mask = '0; ch_dir = '0; ch_block = '0; hlda = 1'b0; ready = 1'b1;
    do_reset();
    check("reset state dut0", st0, RST_VEC);
    check("reset state dut1", st1, RST_VEC);

    // T1: ch1 single, count 0, I/O->memory, hlda two cycles after hrq
    ch_dir = 4'b0010; ch_block = 4'b0000;
    write_cnt(2'd1, 16'd0);
    push_both(2'd1, 1'b1);
    dreq = 4'b0010;
    tick();
    check("t1 hrq after dreq", hrq0, 1);
    check("t1 aen in HREQ", aen0, 0);
    tick(); tick();
    hlda = 1'b1;
    tick();
    check("t1 S1 aen/dack", {aen0, dack0}, {1'b1, 4'b0010});
    check("t1 S1 strobes", {ior_n0, iow_n0, memr_n0, memw_n0}, 4'b1111);
    tick();
    check("t1 S2 strobes", {ior_n0, iow_n0, memr_n0, memw_n0}, 4'b0111);
    tick();
    check("t1 S3 strobes", {ior_n0, iow_n0, memr_n0, memw_n0}, 4'b0110);
    tick();
    check("t1 S4 strobes/inc/eop", {ior_n0, iow_n0, memr_n0, memw_n0, addr_inc0, eop0}, 6'b111111);
    tick();
    check("t1 hrq drop", hrq0, 0);
    check("t1 tc_status", tc0, 4'b0010);
    tick();
    check("t1 no re-request at TC", hrq0, 0);
    dreq = '0; hlda = 1'b0;

    // T2: ch0 block, count 3 -> four back-to-back transfers
    do_reset();
    ch_dir = 4'b0000; ch_block = 4'b0001;
    write_cnt(2'd0, 16'd3);
    for (int i = 0; i < 3; i++) push_both(2'd0, 1'b0);
    push_both(2'd0, 1'b1);
    hlda = 1'b1; dreq = 4'b0001;
    for (int i = 0; i < 8 && aen0 !== 1'b1; i++) tick();
    check("t2 reach S1", aen0, 1);
    n_inc = 0; n_hrq_lo = 0; eop_at = 99;
    for (int i = 0; i < 16; i++) begin
      if (addr_inc0) n_inc++;
      if (!hrq0) n_hrq_lo++;
      if (eop0) eop_at = i;
      tick();
    end
    check("t2 addr_inc count", n_inc, 4);
    check("t2 hrq low cycles", n_hrq_lo, 0);
    check("t2 eop cycle", eop_at, 15);
    check("t2 hrq drop at TC", hrq0, 0);
    check("t2 tc_status", tc0, 4'b0001);
    dreq = '0;

    // T3: all four requesting, single mode: fixed vs rotating order
    do_reset();
    ch_block = 4'b0000;
    for (int c = 0; c < 4; c++) write_cnt(2'(c), 16'd5);
    for (int i = 0; i < 5; i++) q0.push_back('{ch: 2'd0, eop: 1'b0});
    for (int i = 0; i < 5; i++) q1.push_back('{ch: 2'(i % 4), eop: 1'b0});
    hlda = 1'b1; dreq = 4'b1111;
    n_inc = 0;
    for (int i = 0; i < 60 && n_inc < 5; i++) begin
      tick();
      if (addr_inc0) n_inc++;
    end
    dreq = '0;
    check("t3 transfers seen", n_inc, 5);
    tick(); tick();
    check("t3 idle after drop", {hrq0, hrq1}, 2'b00);
    check("t3 no TC dut0", tc0, 4'b0000);
    check("t3 no TC dut1", tc1, 4'b0000);

    // T4a: three wait cycles in S3
    do_reset();
    ch_dir = 4'b0100;
    write_cnt(2'd2, 16'd1);
    push_both(2'd2, 1'b0);
    ready = 1'b0; hlda = 1'b1; dreq = 4'b0100;
    for (int i = 0; i < 16 && memw_n0 !== 1'b0; i++) tick();
    check("t4 reach S3", memw_n0, 0);
    s3_len = 0; n_err = 0;
    for (int i = 0; i < 20 && memw_n0 === 1'b0; i++) begin
      s3_len++;
      if (err0) n_err++;
      if (s3_len >= 4) ready = 1'b1;
      tick();
    end
    dreq = '0;
    check("t4 S3 length", s3_len, 4);
    check("t4 S4 after waits", addr_inc0, 1);
    tick();
    check("t4 no err", {n_err[0], err0}, 2'b00);

    // T4b: ready held low past WAIT_MAX -> err, count untouched
    write_cnt(2'd2, 16'd1);
    ready = 1'b0; dreq = 4'b0100;
    for (int i = 0; i < 16 && memw_n0 !== 1'b0; i++) tick();
    check("t4b reach S3", memw_n0, 0);
    s3_len = 0;
    for (int i = 0; i < 40 && err0 !== 1'b1; i++) begin
      if (memw_n0 === 1'b0) s3_len++;
      tick();
    end
    check("t4b timeout err", err0, 1);
    check("t4b S3 cycles before err", s3_len, 16);
    check("t4b bus released", {aen0, dack0, ior_n0, iow_n0, memr_n0, memw_n0}, {1'b0, 4'b0000, 4'b1111});
    dreq = '0; ready = 1'b1;
    tick();
    check("t4b err one cycle", err0, 0);
    push_both(2'd2, 1'b0);
    push_both(2'd2, 1'b1);
    dreq = 4'b0100;
    for (int i = 0; i < 40 && tc0[2] !== 1'b1; i++) tick();
    check("t4b TC after two transfers", tc0, 4'b0100);
    dreq = '0;

    // T5: hlda dropped in S2
    do_reset();
    ch_dir = 4'b0000; ch_block = 4'b1000;
    write_cnt(2'd3, 16'd2);
    hlda = 1'b1; dreq = 4'b1000;
    for (int i = 0; i < 16 && memr_n0 !== 1'b0; i++) tick();
    check("t5 reach S2", memr_n0, 0);
    check("t5 cur_ch", cur0, 3);
    hlda = 1'b0;
    tick();
    check("t5 err pulse", err0, 1);
    check("t5 bus released", {aen0, dack0, ior_n0, iow_n0, memr_n0, memw_n0}, {1'b0, 4'b0000, 4'b1111});
    tick();
    check("t5 re-request", {hrq0, err0, aen0}, 3'b100);
    push_both(2'd3, 1'b0);
    push_both(2'd3, 1'b0);
    push_both(2'd3, 1'b1);
    hlda = 1'b1;
    for (int i = 0; i < 60 && tc0[3] !== 1'b1; i++) tick();
    check("t5 TC after full count", tc0, 4'b1000);
    dreq = '0; hlda = 1'b0;

    // T6: counter writes during a transfer, then reset in S3
    do_reset();
    ch_dir = 4'b0000; ch_block = 4'b0000; hlda = 1'b1;
    write_cnt(2'd1, 16'd0);
    push_both(2'd1, 1'b1);
    dreq = 4'b0010;
    for (int i = 0; i < 20 && tc0[1] !== 1'b1; i++) tick();
    check("t6 ch1 TC", tc0, 4'b0010);
    dreq = '0;
    write_cnt(2'd0, 16'd1);
    push_both(2'd0, 1'b0);
    ready = 1'b0; dreq = 4'b0001;
    for (int i = 0; i < 16 && iow_n0 !== 1'b0; i++) tick();
    check("t6 reach S3", iow_n0, 0);
    write_cnt(2'd0, 16'd0);
    write_cnt(2'd1, 16'd0);
    check("t6 idle-channel write clears TC", tc0, 4'b0000);
    ready = 1'b1;
    for (int i = 0; i < 8 && addr_inc0 !== 1'b1; i++) tick();
    check("t6 ch0 S4", addr_inc0, 1);
    dreq = 4'b0010; ready = 1'b0;
    for (int i = 0; i < 16 && iow_n0 !== 1'b0; i++) tick();
    check("t6 ch1 in S3", {iow_n0, cur0}, 3'b001);
    reset = 1'b1;
    tick();
    check("t6 reset in S3 dut0", st0, RST_VEC);
    check("t6 reset in S3 dut1", st1, RST_VEC);
    reset = 1'b0; dreq = '0; ready = 1'b1; hlda = 1'b0;
    tick();
    check("t6 quiet after reset", st0, RST_VEC);

    check("dut0 queue drained", q0.size(), 0);
    check("dut1 queue drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
